img_window_gen: RTL and testbench

Upstream feeder for the 3x3 Gaussian-smoothing convolution stage. It accepts a raster-order pixel stream, one pixel per valid cycle, and keeps the two previous image rows in on-chip line buffers. For every input pixel that completes a full 3x3 neighbourhood, it emits the nine pixels in parallel. The convolution stage can then take one window per cycle instead of storing the whole Img_W x Img_H frame itself.

---
 rtl/img_window_gen.sv | 134 +++++++++++++
 tb/tb_img_window_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/img_window_gen.sv
// img_window_gen
//   Turns a raster-order pixel stream into 3x3 neighbourhoods for the
//   Gaussian-smoothing stage. Two line buffers hold rows r-1 (lb0) and r-2
//   (lb1); a 3x3 register array slides one column per accepted pixel.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears counters, window and outputs
//   in_pix_data  input pixel, raster order
//   in_pix_valid pixel accepted this cycle (no backpressure)
//   sof          start of frame, qualifies in_pix_valid; forces position (0,0)
//   win_data     3x3 window, element (m,n) at [(3*m+n)*Datawidth +: Datawidth]
//   win_valid    window/row/col valid (one cycle per window)
//   win_row      top-left row of the window
//   win_col      top-left column of the window
//   frame_done   pulse with the last window of a frame
module img_window_gen #(
  parameter int Datawidth = 8,
  parameter int Img_W     = 512,
  parameter int Img_H     = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [Datawidth-1:0]       in_pix_data,
  input  logic                       in_pix_valid,
  input  logic                       sof,
  output logic [9*Datawidth-1:0]     win_data,
  output logic                       win_valid,
  output logic [$clog2(Img_H)-1:0]   win_row,
  output logic [$clog2(Img_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int DW = Datawidth;
  localparam int CW = $clog2(Img_W);
  localparam int RW = $clog2(Img_H);
  localparam logic [CW-1:0] LAST_COL = CW'(Img_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(Img_H - 1);

  logic [CW-1:0]   col_q, col_d, eff_col;
  logic [RW-1:0]   row_q, row_d, eff_row;
  logic [9*DW-1:0] win_q, win_d;
  logic [9*DW-1:0] out_data_q, out_data_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic            out_vld_q, out_vld_d;
  logic            done_q, done_d;
  logic            emit;

  // Line buffers are deliberately not reset; the r>=2 / c>=2 gate keeps
  // stale contents from ever reaching a valid window.
  logic [DW-1:0]   lb0_mem [Img_W];
  logic [DW-1:0]   lb1_mem [Img_W];
  logic [DW-1:0]   lb0_rd, lb1_rd;

  always_comb begin
    // sof overrides the counters so the pixel lands at (0,0)
    eff_col    = sof ? '0 : col_q;
    eff_row    = sof ? '0 : row_q;
    // combinational read of the current contents gives read-before-write
    lb0_rd     = lb0_mem[eff_col];
    lb1_rd     = lb1_mem[eff_col];
    col_d      = col_q;
    row_d      = row_q;
    win_d      = win_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    emit       = in_pix_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));

    if (in_pix_valid) begin
      if (eff_col == LAST_COL) begin
        col_d = '0;
        row_d = (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
      for (int m = 0; m < 3; m++) begin
        win_d[(3*m)*DW   +: DW] = win_q[(3*m+1)*DW +: DW];
        win_d[(3*m+1)*DW +: DW] = win_q[(3*m+2)*DW +: DW];
      end
      win_d[2*DW +: DW] = lb1_rd;
      win_d[5*DW +: DW] = lb0_rd;
      win_d[8*DW +: DW] = in_pix_data;
    end

    out_vld_d = emit;
    done_d    = emit && (eff_row == LAST_ROW) && (eff_col == LAST_COL);
    // output fields only update on emission so they hold between windows
    if (emit) begin
      out_data_d = win_d;
      out_row_d  = eff_row - RW'(2);
      out_col_d  = eff_col - CW'(2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      out_vld_q  <= out_vld_d;
      done_q     <= done_d;
    end
  end

  // row r-1 ages into the r-2 buffer as row r overwrites it
  always_ff @(posedge clk) begin
    if (in_pix_valid) begin
      lb1_mem[eff_col] <= lb0_rd;
      lb0_mem[eff_col] <= in_pix_data;
    end
  end

  assign win_data   = out_data_q;
  assign win_valid  = out_vld_q;
  assign win_row    = out_row_q;
  assign win_col    = out_col_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_img_window_gen.sv
module tb_img_window_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;

  typedef struct {
    logic [9*DW-1:0] data;
    logic [2:0]      row;
    logic [2:0]      col;
    logic            done;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   in_pix_data;
  logic            in_pix_valid;
  logic            sof;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic [2:0]      win_row;
  logic [2:0]      win_col;
  logic            frame_done;

  exp_t        sb[$];
  exp_t        held;
  logic [7:0]  img [H][W];
  int          mr, mc;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_win, n_done;

  img_window_gen #(.Datawidth(DW), .Img_W(W), .Img_H(H)) dut (
    .clk(clk), .reset(reset), .in_pix_data(in_pix_data),
    .in_pix_valid(in_pix_valid), .sof(sof), .win_data(win_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // window built directly from the 10*r+c (+base) pattern
  function automatic logic [71:0] win_at(input int base, input int r0, input int c0);
    logic [71:0] v;
    v = '0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        v[(3*m+n)*8 +: 8] = 8'(base + 10*(r0+m) + c0 + n);
    return v;
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    exp_t e;
    logic emit;
    in_pix_valid = v;
    sof          = s;
    in_pix_data  = v ? p : 8'($urandom);
    emit         = 1'b0;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        e.data = '0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            e.data[(3*m+n)*8 +: 8] = img[mr-2+m][mc-2+n];
        e.row  = 3'(mr - 2);
        e.col  = 3'(mc - 2);
        e.done = (mr == H-1) && (mc == W-1);
        sb.push_back(e);
        emit = 1'b1;
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else mc = mc + 1;
    end
    @(posedge clk);
    #1;
    chk("win_valid", win_valid, emit);
    if (emit) begin
      e = sb.pop_front();
      chk("win_data", win_data, e.data);
      chk("win_row", win_row, e.row);
      chk("win_col", win_col, e.col);
      chk("frame_done", frame_done, e.done);
      held = e;
    end else begin
      chk("frame_done_idle", frame_done, 1'b0);
      chk("hold_data", win_data, held.data);
      chk("hold_row", win_row, held.row);
      chk("hold_col", win_col, held.col);
    end
    if (win_valid === 1'b1) n_win++;
    if (frame_done === 1'b1) n_done++;
    in_pix_valid = 1'b0;
    sof          = 1'b0;
  endtask

  task automatic frame(input int base, input bit bubbles, input bit first_sof, input bit rnd);
    n_win  = 0;
    n_done = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (bubbles) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00);
        step(1'b1, first_sof && r == 0 && c == 0,
             rnd ? 8'($urandom) : 8'(base + 10*r + c));
        if (!rnd && r == 2 && c == 2) chk("first_win", win_data, win_at(base, 0, 0));
        if (!rnd && r == H-1 && c == W-1) begin
          chk("last_win", win_data, win_at(base, 2, 2));
          chk("last_done", frame_done, 1'b1);
        end
      end
    chk("win_count", n_win, 9);
    chk("done_count", n_done, 1);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_valid", win_valid, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_data", win_data, '0);
    chk("rst_row", win_row, '0);
    chk("rst_col", win_col, '0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_valid", win_valid, 1'b0);
    reset = 1'b0;
    mr = 0;
    mc = 0;
    sb.delete();
    held.data = '0;
    held.row  = '0;
    held.col  = '0;
    held.done = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    in_pix_valid = 1'b0;
    sof          = 1'b0;
    in_pix_data  = '0;
    mr = 0;
    mc = 0;

    do_reset();

    // gap-free 5x5 frame starting with sof
    frame(0, 1'b0, 1'b1, 1'b0);
    // same frame with bubbles, entered through the natural wrap
    frame(0, 1'b1, 1'b0, 1'b0);

    // back-to-back frames, second one without sof
    frame(0, 1'b0, 1'b1, 1'b0);
    frame(100, 1'b0, 1'b0, 1'b0);

    // abandon a frame with sof at (3,1)
    n_win  = 0;
    n_done = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(10*(i/W) + (i%W)));
    chk("partial_wins", n_win, 3);
    chk("partial_done", n_done, 0);
    frame(0, 1'b0, 1'b1, 1'b0);

    // reset in the cycle a window is being presented
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("pre_rst_valid", win_valid, 1'b1);
    do_reset();
    frame(0, 1'b1, 1'b0, 1'b1);
    frame(0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
